// File: rtl/multi_port_register_file_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM encoding
// and default parameter values.
package multi_port_register_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

    localparam int unsigned DEF_BIT_WIDTH = 32;
    localparam int unsigned DEF_REG_COUNT = 8;
    localparam int unsigned DEF_ZERO_REG  = 0;

endpackage

// File: rtl/multi_port_register_file_rf_read_port.sv
// One registered read port: address mux, write-through bypass, optional
// hardwired-zero register 0, output data register and valid flag.
module rf_read_port
    import multi_port_register_file_pkg::*;
#(
    parameter int P_BitWidth = DEF_BIT_WIDTH,
    parameter int P_RegCount = DEF_REG_COUNT,
    parameter int P_ZeroReg  = DEF_ZERO_REG
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [P_BitWidth-1:0]         regs [P_RegCount],
    input  logic [$clog2(P_RegCount)-1:0] rd_addr,
    input  logic                          read,
    input  logic                          wr_en,
    input  logic [$clog2(P_RegCount)-1:0] wr_addr,
    input  logic [P_BitWidth-1:0]         wr_data,
    input  logic                          busy,
    output logic [P_BitWidth-1:0]         rd_data,
    output logic                          valid
);

    localparam bit ZERO_REG = (P_ZeroReg != 0);

    logic [P_BitWidth-1:0] sel_data;

    // NOTE: sel_data gets a default before any condition so no latch is inferred.
    always_comb begin
        sel_data = regs[rd_addr];
        if (wr_en && (wr_addr == rd_addr))
            sel_data = wr_data;
        if (ZERO_REG && (rd_addr == '0))
            sel_data = '0;
    end

    // Data is captured even while busy; only the valid flag is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            valid   <= 1'b0;
        end else if (read) begin
            rd_data <= sel_data;
            valid   <= !busy;
        end else begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_port_register_file.sv
// Register file with one write port, two independent 1-cycle read ports and
// a sequential bulk-clear engine that zeroes one register per cycle.
module multi_port_register_file
    import multi_port_register_file_pkg::*;
#(
    parameter int P_BitWidth = DEF_BIT_WIDTH,
    parameter int P_RegCount = DEF_REG_COUNT,
    parameter int P_ZeroReg  = DEF_ZERO_REG
) (
    input  logic                          In_Clock_50MHz,
    input  logic                          In_Reset,
    input  logic [$clog2(P_RegCount)-1:0] In_WrAddr,
    input  logic [P_BitWidth-1:0]         In_WrData,
    input  logic                          In_Write,
    input  logic [$clog2(P_RegCount)-1:0] In_RdAddrA,
    input  logic [$clog2(P_RegCount)-1:0] In_RdAddrB,
    input  logic                          In_ReadA,
    input  logic                          In_ReadB,
    output logic [P_BitWidth-1:0]         Out_ReadDataA,
    output logic [P_BitWidth-1:0]         Out_ReadDataB,
    output logic                          Out_ValidA,
    output logic                          Out_ValidB,
    input  logic                          In_Clear,
    output logic                          Out_Busy
);

    localparam int AW       = $clog2(P_RegCount);
    localparam bit ZERO_REG = (P_ZeroReg != 0);

    logic [P_BitWidth-1:0] regs [P_RegCount];
    clear_state_t          state, next_state;
    logic [AW-1:0]         clr_idx;
    logic                  busy;
    logic                  wr_en;

    assign wr_en = In_Write && !busy && !(ZERO_REG && (In_WrAddr == '0));

    // Clear FSM: state register and sweep counter.
    always_ff @(posedge In_Clock_50MHz or posedge In_Reset) begin
        if (In_Reset) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE)
                clr_idx <= '0;
            else
                clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (In_Clear) next_state = CLEAR;
            CLEAR:   if (clr_idx == AW'(P_RegCount - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    assign Out_Busy = busy;

    // NOTE: the storage is a plain flop array, so resetting every entry is legal and cheap to reason about.
    always_ff @(posedge In_Clock_50MHz or posedge In_Reset) begin
        if (In_Reset) begin
            for (int i = 0; i < P_RegCount; i++)
                regs[i] <= '0;
        end else if (busy) begin
            regs[clr_idx] <= '0;
        end else if (wr_en) begin
            regs[In_WrAddr] <= In_WrData;
        end
    end

    rf_read_port #(
        .P_BitWidth (P_BitWidth),
        .P_RegCount (P_RegCount),
        .P_ZeroReg  (P_ZeroReg)
    ) u_port_a (
        .clk     (In_Clock_50MHz),
        .rst     (In_Reset),
        .regs    (regs),
        .rd_addr (In_RdAddrA),
        .read    (In_ReadA),
        .wr_en   (wr_en),
        .wr_addr (In_WrAddr),
        .wr_data (In_WrData),
        .busy    (busy),
        .rd_data (Out_ReadDataA),
        .valid   (Out_ValidA)
    );

    rf_read_port #(
        .P_BitWidth (P_BitWidth),
        .P_RegCount (P_RegCount),
        .P_ZeroReg  (P_ZeroReg)
    ) u_port_b (
        .clk     (In_Clock_50MHz),
        .rst     (In_Reset),
        .regs    (regs),
        .rd_addr (In_RdAddrB),
        .read    (In_ReadB),
        .wr_en   (wr_en),
        .wr_addr (In_WrAddr),
        .wr_data (In_WrData),
        .busy    (busy),
        .rd_data (Out_ReadDataB),
        .valid   (Out_ValidB)
    );

endmodule

// File: tb/tb_multi_port_register_file.sv
// Bench driving a plain instance and a zero-register instance with the same
// stimulus and comparing both against an array-based reference model.
module tb_multi_port_register_file;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [W-1:0]  wr_data;
    logic          wr, rd_a, rd_b, clr;

    logic [1:0][W-1:0] rdata_a, rdata_b;
    logic [1:0]        valid_a, valid_b, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 = plain file, index 1 = zero-register file.
    logic [W-1:0] mem [2][N];
    bit           m_busy;
    int           m_idx;
    logic [W-1:0] exp_da [2];
    logic [W-1:0] exp_db [2];
    bit           exp_va [2];
    bit           exp_vb [2];

    multi_port_register_file #(.P_BitWidth(W), .P_RegCount(N), .P_ZeroReg(0)) dut (
        .In_Clock_50MHz (clk),
        .In_Reset       (rst),
        .In_WrAddr      (wr_addr),
        .In_WrData      (wr_data),
        .In_Write       (wr),
        .In_RdAddrA     (rd_addr_a),
        .In_RdAddrB     (rd_addr_b),
        .In_ReadA       (rd_a),
        .In_ReadB       (rd_b),
        .Out_ReadDataA  (rdata_a[0]),
        .Out_ReadDataB  (rdata_b[0]),
        .Out_ValidA     (valid_a[0]),
        .Out_ValidB     (valid_b[0]),
        .In_Clear       (clr),
        .Out_Busy       (busy[0])
    );

    multi_port_register_file #(.P_BitWidth(W), .P_RegCount(N), .P_ZeroReg(1)) dut_z (
        .In_Clock_50MHz (clk),
        .In_Reset       (rst),
        .In_WrAddr      (wr_addr),
        .In_WrData      (wr_data),
        .In_Write       (wr),
        .In_RdAddrA     (rd_addr_a),
        .In_RdAddrB     (rd_addr_b),
        .In_ReadA       (rd_a),
        .In_ReadB       (rd_b),
        .Out_ReadDataA  (rdata_a[1]),
        .Out_ReadDataB  (rdata_b[1]),
        .Out_ValidA     (valid_a[1]),
        .Out_ValidB     (valid_b[1]),
        .In_Clear       (clr),
        .Out_Busy       (busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < N; i++) mem[z][i] = '0;
            exp_da[z] = '0; exp_db[z] = '0;
            exp_va[z] = 1'b0; exp_vb[z] = 1'b0;
        end
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    function automatic logic [W-1:0] read_val(int z, logic [AW-1:0] addr, bit we);
        if (z == 1 && addr == 0) return '0;
        if (we && wr_addr == addr) return wr_data;
        return mem[z][addr];
    endfunction

    // One rising edge of the reference, using the inputs held across that edge.
    task automatic model_edge();
        bit busy_pre;
        bit we;
        busy_pre = m_busy;
        for (int z = 0; z < 2; z++) begin
            we = wr && !busy_pre && !(z == 1 && wr_addr == 0);
            if (rd_a) begin
                exp_da[z] = read_val(z, rd_addr_a, we);
                exp_va[z] = !busy_pre;
            end else begin
                exp_va[z] = 1'b0;
            end
            if (rd_b) begin
                exp_db[z] = read_val(z, rd_addr_b, we);
                exp_vb[z] = !busy_pre;
            end else begin
                exp_vb[z] = 1'b0;
            end
            if (busy_pre)  mem[z][m_idx] = '0;
            else if (we)   mem[z][wr_addr] = wr_data;
        end
        if (busy_pre) begin
            m_idx++;
            if (m_idx == N) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end
        end else if (clr) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end
    endtask

    task automatic check_outputs(input string where);
        for (int z = 0; z < 2; z++) begin
            check($sformatf("%s[z%0d] data_a", where, z), rdata_a[z], exp_da[z]);
            check($sformatf("%s[z%0d] data_b", where, z), rdata_b[z], exp_db[z]);
            check($sformatf("%s[z%0d] valid_a", where, z), W'(valid_a[z]), W'(exp_va[z]));
            check($sformatf("%s[z%0d] valid_b", where, z), W'(valid_b[z]), W'(exp_vb[z]));
            check($sformatf("%s[z%0d] busy", where, z), W'(busy[z]), W'(m_busy));
        end
    endtask

    task automatic tick(input string where);
        @(posedge clk);
        #1;
        model_edge();
        check_outputs(where);
    endtask

    task automatic idle_inputs();
        wr = 0; rd_a = 0; rd_b = 0; clr = 0;
        wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0; wr_data = '0;
    endtask

    task automatic read_all(input string where);
        wr = 0; clr = 0; rd_a = 1; rd_b = 1;
        for (int i = 0; i < N; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(N - 1 - i);
            tick(where);
        end
        rd_a = 0; rd_b = 0;
    endtask

    task automatic fill_all(input string where);
        wr = 1; clr = 0;
        for (int i = 0; i < N; i++) begin
            wr_addr = AW'(i);
            wr_data = $urandom | 32'h1;
            tick(where);
        end
        wr = 0;
    endtask

    int busy_cycles;

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #25;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Read of an untouched register straight after reset.
        rd_a = 1; rd_addr_a = 3;
        tick("read_after_reset");
        check("read_after_reset valid_a", W'(valid_a[0]), W'(1));
        check("read_after_reset data_a", rdata_a[0], 32'h0);

        // Write then read on both ports.
        rd_a = 0; wr = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick("write5");
        wr = 0; rd_a = 1; rd_b = 1; rd_addr_a = 5; rd_addr_b = 5;
        tick("read5");
        check("read5 data_a", rdata_a[0], 32'hDEADBEEF);
        check("read5 data_b", rdata_b[0], 32'hDEADBEEF);

        // Same-edge write-through bypass.
        rd_b = 0; wr = 1; wr_addr = 2; wr_data = 32'h12345678; rd_addr_a = 2;
        tick("bypass2");
        check("bypass2 data_a", rdata_a[0], 32'h12345678);

        // Register 0 write: kept by the plain file, discarded by the zero file.
        wr = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rd_addr_a = 0;
        tick("zero_same_edge");
        check("zero_same_edge z1 data_a", rdata_a[1], 32'h0);
        wr = 0;
        tick("zero_later");
        check("zero_later z1 data_a", rdata_a[1], 32'h0);
        check("zero_later z0 data_a", rdata_a[0], 32'hFFFFFFFF);
        rd_a = 0;

        // Full bulk clear, with write on the trigger edge and traffic while busy.
        fill_all("fill");
        clr = 1; wr = 1; wr_addr = 6; wr_data = 32'hA5A5A5A5;
        rd_a = 1; rd_addr_a = 1;
        tick("clear_start");
        busy_cycles = busy[0] ? 1 : 0;
        clr = 0;
        for (int c = 0; c < N; c++) begin
            wr = 1; wr_addr = AW'($urandom_range(0, N - 1)); wr_data = $urandom;
            rd_a = 1; rd_addr_a = AW'($urandom_range(0, N - 1));
            clr = (c == 3);
            tick("clearing");
            if (busy[0]) busy_cycles++;
        end
        check("busy_cycles", W'(busy_cycles), W'(N));
        read_all("after_clear");

        // Reset in the middle of a clear sweep.
        fill_all("refill");
        clr = 1;
        tick("clear2_start");
        clr = 0;
        for (int c = 0; c < 2; c++) tick("clear2_run");
        #4;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("reset_mid_clear");
        @(negedge clk);
        rst = 1'b0;
        read_all("after_abort");

        // Randomized traffic, including occasional clears.
        for (int c = 0; c < 600; c++) begin
            wr        = $urandom_range(0, 1);
            wr_addr   = AW'($urandom_range(0, N - 1));
            wr_data   = $urandom;
            rd_a      = ($urandom_range(0, 3) != 0);
            rd_b      = ($urandom_range(0, 3) != 0);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, N - 1));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, N - 1));
            clr       = ($urandom_range(0, 39) == 0);
            tick("random");
        end
        idle_inputs();
        read_all("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_port_register_file.md
MULTI_PORT_REGISTER_FILE -- requirements
Module: multi_port_register_file

Interface
REQ-001 SHALL have parameter P_BitWidth, default 32, data width in bits.
REQ-002 SHALL have parameter P_RegCount, default 8, number of registers (power of two, >=2); address width AW = clog2(P_RegCount).
REQ-003 SHALL have parameter P_ZeroReg, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL have port In_Clock_50MHz  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port In_Reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports In_WrAddr  input  AW, In_WrData  input  P_BitWidth, In_Write  input  1  (write port).
REQ-007 SHALL have ports In_RdAddrA/In_RdAddrB  input  AW, In_ReadA/In_ReadB  input  1  (two read-request ports).
REQ-008 SHALL have ports Out_ReadDataA/Out_ReadDataB  output  P_BitWidth, Out_ValidA/Out_ValidB  output  1  (registered read results).
REQ-009 SHALL have ports In_Clear  input  1 (bulk-clear request), Out_Busy  output  1 (clear in progress).

Function
REQ-010 Write: In_Write high at an edge, Out_Busy low -> register In_WrAddr takes In_WrData at that edge.
REQ-011 Read latency exactly 1 cycle: In_ReadX high at edge N -> Out_ReadDataX holds data, Out_ValidX high, after edge N.
REQ-012 Out_ValidX SHALL be low the cycle after any edge with In_ReadX low; Out_ReadDataX SHALL hold its last value when not reading.
REQ-013 Write-through bypass: read and write same address same edge -> read returns In_WrData (new value).
REQ-014 Ports A and B independent; same address on both legal, both return identical data.
REQ-015 P_ZeroReg=1: writes to address 0 discarded; reads of address 0 return 0, bypass suppressed for address 0.
REQ-016 Clear FSM states IDLE, CLEAR. IDLE->CLEAR on In_Clear high; counter loads 0.
REQ-017 In CLEAR, one register per cycle zeroed at counter index, counter increments; after index P_RegCount-1 cleared, return to IDLE.
REQ-018 Out_Busy high exactly while in CLEAR (P_RegCount cycles per clear).
REQ-019 During CLEAR: In_Write ignored; In_ReadX still served, Out_ValidX forced low.
REQ-020 In_Clear while in CLEAR ignored (no restart); In_Clear and In_Write same edge in IDLE -> write performed, then clear begins next cycle and erases it.
REQ-021 Out-of-range addresses impossible (power-of-two count); no wrap logic beyond AW-bit counter.

Reset
REQ-022 In_Reset high asynchronously SHALL zero all registers, Out_ReadDataA/B=0, Out_ValidA/B=0, Out_Busy=0, FSM=IDLE, counter=0.
REQ-023 Reset mid-CLEAR SHALL abort the clear immediately; no pending clear after release.
REQ-024 First edge after reset deassertion SHALL accept writes/reads normally.

Structure
REQ-025 Shared package SHALL hold clear-FSM state encoding (IDLE=0, CLEAR=1) and default parameter constants.
REQ-026 One sub-module natural: rf_read_port (address mux, bypass, zero-reg, output register, valid), instantiated twice.
REQ-027 Storage SHALL be flop array inside top level; no memory macro inference required.

Verification
REQ-028 Reset, then read A addr 3 -> after 1 edge Out_ReadDataA=0, Out_ValidA=1.
REQ-029 Write 0xDEADBEEF to addr 5; next cycle read A and B addr 5 -> both 0xDEADBEEF, valid 1.
REQ-030 Same-edge write 0x12345678 addr 2 plus read A addr 2 -> Out_ReadDataA=0x12345678 next cycle.
REQ-031 P_ZeroReg=1: write 0xFFFFFFFF addr 0, read addr 0 (same edge and later) -> 0.
REQ-032 Fill all 8 registers, pulse In_Clear -> Out_Busy high 8 cycles, write during busy ignored, Out_ValidA low during busy; afterward all reads 0.
REQ-033 Assert In_Reset at cycle 3 of CLEAR -> Out_Busy drops asynchronously, all registers 0, FSM IDLE after release.
